// File: rtl/mips_defs_pkg.sv
// Shared MIPS-subset encodings: opcodes, funct codes, ALU commands,
// register-destination selects and the fetch state encoding.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;

    localparam logic [1:0] DST_RD   = 2'd0;
    localparam logic [1:0] DST_RT   = 2'd1;
    localparam logic [1:0] DST_R31  = 2'd2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode/funct decode into datapath controls,
// control-transfer class flags and an illegal-instruction flag.
module control_decode
    import mips_defs::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       reg_wr,
    output logic       mem_wr,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic [1:0] reg_dst,
    output logic [2:0] alu_cntrl,
    output logic       link_sel,
    output logic       is_beq,
    output logic       is_bne,
    output logic       is_jump,
    output logic       is_jr,
    output logic       illegal
);

    // Opcode/funct decode; unknown encodings leave every enable low.
    always_comb begin
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        reg_dst    = DST_RD;
        alu_cntrl  = ALU_ADD;
        link_sel   = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_jump    = 1'b0;
        is_jr      = 1'b0;
        illegal    = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin
                        reg_wr = 1'b1;
                    end
                    FN_SUB: begin
                        reg_wr    = 1'b1;
                        alu_cntrl = ALU_SUB;
                    end
                    FN_SLT: begin
                        reg_wr    = 1'b1;
                        alu_cntrl = ALU_SLT;
                    end
                    FN_JR: begin
                        is_jr = 1'b1;
                    end
                    default: begin
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                reg_wr  = 1'b1;
                reg_dst = DST_RT;
                alu_src = 1'b1;
            end
            OP_XORI: begin
                reg_wr    = 1'b1;
                reg_dst   = DST_RT;
                alu_src   = 1'b1;
                alu_cntrl = ALU_XOR;
            end
            OP_LW: begin
                reg_wr     = 1'b1;
                reg_dst    = DST_RT;
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                mem_wr  = 1'b1;
                alu_src = 1'b1;
            end
            OP_BEQ: begin
                alu_cntrl = ALU_SUB;
                is_beq    = 1'b1;
            end
            OP_BNE: begin
                alu_cntrl = ALU_SUB;
                is_bne    = 1'b1;
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            OP_JAL: begin
                is_jump  = 1'b1;
                reg_wr   = 1'b1;
                reg_dst  = DST_R31;
                link_sel = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_control.sv
// Fetch/control stage: PC, RUN/HALT state, retired counter and next-PC
// resolution. Define DELAY_SLOT_EN for MIPS branch-delay-slot semantics.
module fetch_control
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic               stall,
    input  logic               alu_zero,
    input  logic [31:0]        rs_data,
    output logic [31:0]        pc,
    output logic               RegWr,
    output logic               MemWr,
    output logic               MemToReg,
    output logic               ALUSrc,
    output logic [1:0]         RegDst,
    output logic [2:0]         ALUcntrl,
    output logic [4:0]         Rs,
    output logic [4:0]         Rt,
    output logic [4:0]         Rd,
    output logic [4:0]         R31,
    output logic [15:0]        imm16,
    output logic               link_sel,
    output logic [31:0]        link_addr,
    output logic               halted,
    output logic [COUNT_W-1:0] retired
);

    state_t               state_r, state_next_s;
    logic [31:0]          pc_r, pc_next_s, pc_plus4_s, target_s;
    logic [COUNT_W-1:0]   retired_r;
    logic                 dec_reg_wr_s, dec_mem_wr_s, dec_illegal_s;
    logic                 is_beq_s, is_bne_s, is_jump_s, is_jr_s;
    logic                 ctrl_xfer_s, taken_s, illegal_s, advance_s, retire_s;

    control_decode u_decode (
        .op         (instr[31:26]),
        .funct      (instr[5:0]),
        .reg_wr     (dec_reg_wr_s),
        .mem_wr     (dec_mem_wr_s),
        .mem_to_reg (MemToReg),
        .alu_src    (ALUSrc),
        .reg_dst    (RegDst),
        .alu_cntrl  (ALUcntrl),
        .link_sel   (link_sel),
        .is_beq     (is_beq_s),
        .is_bne     (is_bne_s),
        .is_jump    (is_jump_s),
        .is_jr      (is_jr_s),
        .illegal    (dec_illegal_s)
    );

    assign pc_plus4_s  = pc_r + 32'd4;
    assign ctrl_xfer_s = is_beq_s | is_bne_s | is_jump_s | is_jr_s;
    assign taken_s     = (is_beq_s & alu_zero) | (is_bne_s & ~alu_zero) | is_jump_s | is_jr_s;
    assign advance_s   = (state_r == ST_RUN) & ~stall;
    assign retire_s    = advance_s & ~illegal_s;

    // Redirect target for whichever control transfer is being decoded.
    always_comb begin
        target_s = pc_plus4_s + {{14{instr[15]}}, instr[15:0], 2'b00};
        if (is_jr_s) begin
            target_s = rs_data;
        end else if (is_jump_s) begin
            target_s = {pc_plus4_s[31:28], instr[25:0], 2'b00};
        end else begin
            target_s = pc_plus4_s + {{14{instr[15]}}, instr[15:0], 2'b00};
        end
    end

`ifdef DELAY_SLOT_EN
    logic        pending_valid_r;
    logic [31:0] pending_target_r;

    // A control transfer sitting in a delay slot is treated as illegal.
    assign illegal_s = dec_illegal_s | (pending_valid_r & ctrl_xfer_s);
    assign link_addr = pc_r + 32'd8;

    // Next PC: the slot instruction retires, then the stored target loads.
    always_comb begin
        pc_next_s = pc_plus4_s;
        if (pending_valid_r) begin
            pc_next_s = pending_target_r;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // Pending redirect register; held across stalls and HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_valid_r  <= 1'b0;
            pending_target_r <= 32'h0000_0000;
        end else if (retire_s) begin
            pending_valid_r  <= taken_s;
            pending_target_r <= taken_s ? target_s : pending_target_r;
        end else begin
            pending_valid_r  <= pending_valid_r;
            pending_target_r <= pending_target_r;
        end
    end
`else
    assign illegal_s = dec_illegal_s;
    assign link_addr = pc_plus4_s;

    // Next PC: redirects take effect on the same edge.
    always_comb begin
        pc_next_s = pc_plus4_s;
        if (taken_s && !ctrl_xfer_s) begin
            pc_next_s = pc_plus4_s;
        end else if (taken_s) begin
            pc_next_s = target_s;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end
`endif

    // RUN/HALT next-state; HALT is left only through reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN:  state_next_s = (advance_s && illegal_s) ? ST_HALT : ST_RUN;
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_RUN;
        endcase
    end

    // State, PC and saturating retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_RUN;
            pc_r      <= RESET_PC;
            retired_r <= '0;
        end else begin
            state_r <= state_next_s;
            if (retire_s) begin
                pc_r      <= pc_next_s;
                retired_r <= (retired_r == {COUNT_W{1'b1}}) ? retired_r : retired_r + COUNT_W'(1);
            end else begin
                pc_r      <= pc_r;
                retired_r <= retired_r;
            end
        end
    end

    assign RegWr   = dec_reg_wr_s & retire_s & ~reset;
    assign MemWr   = dec_mem_wr_s & retire_s & ~reset;
    assign pc      = pc_r;
    assign retired = retired_r;
    assign halted  = (state_r == ST_HALT);
    assign Rs      = instr[25:21];
    assign Rt      = instr[20:16];
    assign Rd      = instr[15:11];
    assign R31     = 5'd31;
    assign imm16   = instr[15:0];

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control (default build, no delay slot).
module tb_fetch_control;

    logic        clk = 1'b0;
    logic        reset, stall, alu_zero;
    logic [31:0] instr, rs_data;
    logic [31:0] pc, link_addr;
    logic        RegWr, MemWr, MemToReg, ALUSrc, link_sel, halted;
    logic [1:0]  RegDst;
    logic [2:0]  ALUcntrl;
    logic [4:0]  Rs, Rt, Rd, R31;
    logic [15:0] imm16;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADDI = 32'h2022_0005;
    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_BEQ  = 32'h1022_FFFE;
    localparam logic [31:0] I_BNE  = 32'h1422_FFFE;
    localparam logic [31:0] I_J20  = 32'h0800_0008;
    localparam logic [31:0] I_JAL  = 32'h0C00_0040;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    fetch_control dut (
        .clk(clk), .reset(reset), .instr(instr), .stall(stall),
        .alu_zero(alu_zero), .rs_data(rs_data), .pc(pc),
        .RegWr(RegWr), .MemWr(MemWr), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
        .RegDst(RegDst), .ALUcntrl(ALUcntrl), .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .R31(R31), .imm16(imm16), .link_sel(link_sel), .link_addr(link_addr),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic st, input logic z);
        instr    = i;
        stall    = st;
        alu_zero = z;
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b1; alu_zero = 1'b0; rs_data = 32'h0; instr = I_ADDI;
        #1;
        chk("regwr_in_reset", 32'(RegWr), 32'd0);
        tick;
        chk("reset_pc", pc, 32'h0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_retired", retired, 32'd0);
        reset = 1'b0;

        drive(I_ADDI, 1'b0, 1'b0);
        chk("addi_regdst", 32'(RegDst), 32'd1);
        chk("addi_alusrc", 32'(ALUSrc), 32'd1);
        chk("addi_alucntrl", 32'(ALUcntrl), 32'd0);
        chk("addi_regwr", 32'(RegWr), 32'd1);
        chk("addi_rt", 32'(Rt), 32'd2);
        tick;
        chk("addi_pc", pc, 32'h4);

        drive(I_ADD, 1'b0, 1'b0);
        chk("add_regdst", 32'(RegDst), 32'd0);
        chk("add_alusrc", 32'(ALUSrc), 32'd0);
        chk("add_rd", 32'(Rd), 32'd3);
        tick;
        chk("add_pc", pc, 32'h8);
        chk("add_retired", retired, 32'd2);

        drive(I_ADDI, 1'b0, 1'b0); tick;
        drive(I_ADDI, 1'b0, 1'b0); tick;
        chk("pc_at_10", pc, 32'h10);

        drive(I_BEQ, 1'b0, 1'b1);
        chk("beq_alucntrl", 32'(ALUcntrl), 32'd1);
        chk("beq_regwr", 32'(RegWr), 32'd0);
        tick;
        chk("beq_taken_pc", pc, 32'h0C);
        drive(I_ADDI, 1'b0, 1'b0); tick;
        drive(I_BEQ, 1'b0, 1'b0); tick;
        chk("beq_not_taken_pc", pc, 32'h14);
        drive(I_BNE, 1'b0, 1'b0); tick;
        chk("bne_taken_pc", pc, 32'h10);
        drive(I_BNE, 1'b0, 1'b1); tick;
        chk("bne_not_taken_pc", pc, 32'h14);
        drive(I_J20, 1'b0, 1'b0); tick;
        chk("j_pc", pc, 32'h20);

        drive(I_JAL, 1'b0, 1'b0);
        chk("jal_regdst", 32'(RegDst), 32'd2);
        chk("jal_link_sel", 32'(link_sel), 32'd1);
        chk("jal_link_addr", link_addr, 32'h24);
        chk("jal_regwr", 32'(RegWr), 32'd1);
        tick;
        chk("jal_pc", pc, 32'h100);

        rs_data = 32'h24;
        drive(I_JR, 1'b0, 1'b0);
        chk("jr_regwr", 32'(RegWr), 32'd0);
        chk("jr_memwr", 32'(MemWr), 32'd0);
        tick;
        chk("jr_pc", pc, 32'h24);
        chk("retired_12", retired, 32'd12);

        for (int k = 0; k < 3; k++) begin
            drive(I_SW, 1'b1, 1'b0);
            chk("stall_memwr", 32'(MemWr), 32'd0);
            tick;
            chk("stall_pc", pc, 32'h24);
            chk("stall_retired", retired, 32'd12);
        end
        drive(I_SW, 1'b0, 1'b0);
        chk("sw_memwr", 32'(MemWr), 32'd1);
        tick;
        chk("sw_pc", pc, 32'h28);
        drive(I_ADDI, 1'b0, 1'b0);
        chk("after_sw_memwr", 32'(MemWr), 32'd0);

        reset = 1'b1; tick; reset = 1'b0;
        drive(I_ADDI, 1'b0, 1'b0); tick;
        drive(I_ADD, 1'b0, 1'b0); tick;
        chk("pre_illegal_pc", pc, 32'h8);
        drive(I_BAD, 1'b0, 1'b0);
        chk("illegal_regwr", 32'(RegWr), 32'd0);
        tick;
        chk("halted_set", 32'(halted), 32'd1);
        chk("halt_pc", pc, 32'h8);
        chk("halt_retired", retired, 32'd2);
        drive(I_SW, 1'b0, 1'b0);
        chk("halt_memwr", 32'(MemWr), 32'd0);
        drive(I_ADDI, 1'b0, 1'b0);
        chk("halt_regwr", 32'(RegWr), 32'd0);
        tick;
        chk("halt_pc_hold", pc, 32'h8);
        chk("halt_hold", 32'(halted), 32'd1);

        reset = 1'b1; tick; reset = 1'b0;
        chk("reset_exit_halt", 32'(halted), 32'd0);
        chk("reset_exit_pc", pc, 32'h0);
        chk("reset_exit_retired", retired, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
